// File: rtl/pwm_ramp.sv
// PWM duty-cycle ramp generator: steps a compare value once every period_div timer periods.
// Triangle ramp by default; define PWM_RAMP_SAWTOOTH_EN for an up-only sawtooth ramp.
module pwm_ramp #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             top_match,
  input  logic [WIDTH-1:0] top_cnt,
  input  logic [WIDTH-1:0] step,
  input  logic [WIDTH-1:0] period_div,
  output logic [WIDTH-1:0] cmp_cnt,
  output logic             relatch,
  output logic             dir
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    LATCH = 2'd2
  } state_e;

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  state_e           state_q, state_d;
  logic [WIDTH-1:0] div_q, div_d;
  logic [WIDTH-1:0] cmp_q, cmp_d;
  logic             dir_q, dir_d;

  logic [WIDTH-1:0] div_last;
  logic [WIDTH:0]   up_sum;
  logic [WIDTH-1:0] upd_cmp;
  logic             upd_dir;

  // A period_div of 0 behaves like 1, so the terminal divider value is 0 in both cases.
  assign div_last = (period_div == '0) ? '0 : (period_div - ONE);
  assign up_sum   = {1'b0, cmp_q} + {1'b0, step};

  // Value the compare register takes if an update happens this cycle.
  always_comb begin
    // NOTE: every comb output gets a default first so no path leaves it unassigned (no latches).
    upd_cmp = cmp_q;
    upd_dir = dir_q;
`ifdef PWM_RAMP_SAWTOOTH_EN
    upd_dir = 1'b0;
    if (cmp_q > top_cnt) begin
      upd_cmp = top_cnt;
    end else if (step != '0) begin
      if (cmp_q == top_cnt) begin
        upd_cmp = '0;
      end else if (up_sum >= {1'b0, top_cnt}) begin
        upd_cmp = top_cnt;
      end else begin
        upd_cmp = up_sum[WIDTH-1:0];
      end
    end
`else
    if (cmp_q > top_cnt) begin
      upd_cmp = top_cnt;
      upd_dir = 1'b1;
    end else if (step != '0) begin
      if (!dir_q) begin
        if (up_sum >= {1'b0, top_cnt}) begin
          upd_cmp = top_cnt;
          upd_dir = 1'b1;
        end else begin
          upd_cmp = up_sum[WIDTH-1:0];
        end
      end else begin
        if (step >= cmp_q) begin
          upd_cmp = '0;
          upd_dir = 1'b0;
        end else begin
          upd_cmp = cmp_q - step;
        end
      end
    end
`endif
  end

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    cmp_d   = cmp_q;
    dir_d   = dir_q;
    unique case (state_q)
      IDLE: begin
        if (en) begin
          state_d = WAIT;
          div_d   = '0;
        end
      end
      WAIT: begin
        if (!en) begin
          state_d = IDLE;
          div_d   = '0;
        end else if (div_q > div_last) begin
          // Interval already completed (match counted during LATCH or period_div lowered).
          state_d = LATCH;
          cmp_d   = upd_cmp;
          dir_d   = upd_dir;
          div_d   = top_match ? ONE : '0;
        end else if (top_match) begin
          if (div_q == div_last) begin
            state_d = LATCH;
            cmp_d   = upd_cmp;
            dir_d   = upd_dir;
            div_d   = '0;
          end else begin
            div_d = div_q + ONE;
          end
        end
      end
      LATCH: begin
        if (!en) begin
          state_d = IDLE;
          div_d   = '0;
        end else begin
          state_d = WAIT;
          div_d   = top_match ? ONE : '0;
        end
      end
      default: begin
        state_d = IDLE;
        div_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (rst) begin
      state_q <= IDLE;
      div_q   <= '0;
      cmp_q   <= '0;
      dir_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      cmp_q   <= cmp_d;
      dir_q   <= dir_d;
    end
  end

  assign cmp_cnt = cmp_q;
  assign dir     = dir_q;
  assign relatch = (state_q == LATCH);

endmodule

// File: tb/tb_pwm_ramp.sv
// Directed self-checking bench for pwm_ramp; expected values follow PWM_RAMP_SAWTOOTH_EN if defined.
module tb_pwm_ramp;

  localparam int WIDTH = 16;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             en = 1'b0;
  logic             top_match = 1'b0;
  logic [WIDTH-1:0] top_cnt = '0;
  logic [WIDTH-1:0] step = '0;
  logic [WIDTH-1:0] period_div = '0;
  logic [WIDTH-1:0] cmp_cnt;
  logic             relatch;
  logic             dir;

  int passed = 0;
  int total  = 0;

  pwm_ramp #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .top_match  (top_match),
    .top_cnt    (top_cnt),
    .step       (step),
    .period_div (period_div),
    .cmp_cnt    (cmp_cnt),
    .relatch    (relatch),
    .dir        (dir)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse();
    top_match = 1'b1;
    tick();
    top_match = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    en = 1'b0;
    top_match = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (cmp_cnt !== 16'd0) $display("FAIL reset_cmp got %0d exp 0", cmp_cnt); else passed++;
    total++; if (relatch !== 1'b0) $display("FAIL reset_relatch got %b exp 0", relatch); else passed++;
    total++; if (dir !== 1'b0) $display("FAIL reset_dir got %b exp 0", dir); else passed++;
  endtask

  task automatic test_unit_ramp();
    do_reset();
    top_cnt = 16'd255; step = 16'd1; period_div = 16'd1; en = 1'b1;
    tick();
    for (int k = 1; k <= 3; k++) begin
      repeat (255) tick();
      total++; if (relatch !== 1'b0) $display("FAIL unit_idle_relatch k=%0d got %b exp 0", k, relatch); else passed++;
      total++; if (cmp_cnt !== 16'(k - 1)) $display("FAIL unit_hold k=%0d got %0d exp %0d", k, cmp_cnt, k - 1); else passed++;
      pulse();
      total++; if (relatch !== 1'b1) $display("FAIL unit_relatch k=%0d got %b exp 1", k, relatch); else passed++;
      total++; if (cmp_cnt !== 16'(k)) $display("FAIL unit_cmp k=%0d got %0d exp %0d", k, cmp_cnt, k); else passed++;
      tick();
      total++; if (relatch !== 1'b0) $display("FAIL unit_one_cycle k=%0d got %b exp 0", k, relatch); else passed++;
    end
  endtask

  task automatic test_ramp_div2();
`ifdef PWM_RAMP_SAWTOOTH_EN
    logic [WIDTH-1:0] exp_c [5] = '{16'd100, 16'd200, 16'd255, 16'd0, 16'd100};
    logic             exp_d [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    int               n = 5;
`else
    logic [WIDTH-1:0] exp_c [7] = '{16'd100, 16'd200, 16'd255, 16'd155, 16'd55, 16'd0, 16'd100};
    logic             exp_d [7] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    int               n = 7;
`endif
    logic [WIDTH-1:0] prev = '0;
    do_reset();
    top_cnt = 16'd255; step = 16'd100; period_div = 16'd2; en = 1'b1;
    tick();
    for (int i = 0; i < n; i++) begin
      pulse();
      repeat (3) tick();
      total++; if (relatch !== 1'b0 || cmp_cnt !== prev) $display("FAIL div2_first i=%0d got relatch=%b cmp=%0d exp 0/%0d", i, relatch, cmp_cnt, prev); else passed++;
      pulse();
      total++; if (relatch !== 1'b1) $display("FAIL div2_relatch i=%0d got %b exp 1", i, relatch); else passed++;
      total++; if (cmp_cnt !== exp_c[i] || dir !== exp_d[i]) $display("FAIL div2_cmp i=%0d got %0d/%b exp %0d/%b", i, cmp_cnt, dir, exp_c[i], exp_d[i]); else passed++;
      prev = exp_c[i];
      repeat (2) tick();
    end
  endtask

  task automatic test_div_zero();
    do_reset();
    top_cnt = 16'd255; step = 16'd10; period_div = 16'd0; en = 1'b1;
    tick();
    for (int i = 1; i <= 4; i++) begin
      pulse();
      total++; if (relatch !== 1'b1 || cmp_cnt !== 16'(10 * i)) $display("FAIL div0 i=%0d got relatch=%b cmp=%0d exp 1/%0d", i, relatch, cmp_cnt, 10 * i); else passed++;
      repeat (3) tick();
    end
  endtask

  task automatic test_top_lowered();
    do_reset();
    top_cnt = 16'd255; step = 16'd100; period_div = 16'd1; en = 1'b1;
    tick();
    pulse(); tick();
    pulse(); tick();
    total++; if (cmp_cnt !== 16'd200) $display("FAIL lower_pre got %0d exp 200", cmp_cnt); else passed++;
    top_cnt = 16'd150;
    tick();
    pulse();
`ifdef PWM_RAMP_SAWTOOTH_EN
    total++; if (cmp_cnt !== 16'd150 || dir !== 1'b0) $display("FAIL lower_clamp got %0d/%b exp 150/0", cmp_cnt, dir); else passed++;
    tick();
    pulse();
    total++; if (cmp_cnt !== 16'd0 || dir !== 1'b0) $display("FAIL lower_wrap got %0d/%b exp 0/0", cmp_cnt, dir); else passed++;
`else
    total++; if (cmp_cnt !== 16'd150 || dir !== 1'b1) $display("FAIL lower_clamp got %0d/%b exp 150/1", cmp_cnt, dir); else passed++;
    tick();
    pulse();
    total++; if (cmp_cnt !== 16'd50 || dir !== 1'b1) $display("FAIL lower_down got %0d/%b exp 50/1", cmp_cnt, dir); else passed++;
`endif
  endtask

  task automatic test_step_zero();
    do_reset();
    top_cnt = 16'd255; step = 16'd40; period_div = 16'd1; en = 1'b1;
    tick();
    pulse(); tick();
    step = 16'd0;
    pulse();
    total++; if (relatch !== 1'b1 || cmp_cnt !== 16'd40 || dir !== 1'b0) $display("FAIL step0 got %b/%0d/%b exp 1/40/0", relatch, cmp_cnt, dir); else passed++;
  endtask

  task automatic test_top_zero();
    do_reset();
    top_cnt = 16'd0; step = 16'd5; period_div = 16'd1; en = 1'b1;
    tick();
    for (int i = 0; i < 2; i++) begin
      pulse();
      total++; if (relatch !== 1'b1 || cmp_cnt !== 16'd0) $display("FAIL top0 i=%0d got %b/%0d exp 1/0", i, relatch, cmp_cnt); else passed++;
      tick();
    end
  endtask

  task automatic test_reset_in_latch();
    do_reset();
    top_cnt = 16'd255; step = 16'd30; period_div = 16'd1; en = 1'b1;
    tick();
    pulse();
    total++; if (relatch !== 1'b1 || cmp_cnt !== 16'd30) $display("FAIL rstl_pre got %b/%0d exp 1/30", relatch, cmp_cnt); else passed++;
    rst = 1'b1;
    top_match = 1'b1;
    tick();
    rst = 1'b0;
    top_match = 1'b0;
    total++; if (relatch !== 1'b0 || cmp_cnt !== 16'd0 || dir !== 1'b0) $display("FAIL rstl_post got %b/%0d/%b exp 0/0/0", relatch, cmp_cnt, dir); else passed++;
    // Back in IDLE: a match sampled in the first enabled cycle must be ignored.
    pulse();
    tick();
    total++; if (relatch !== 1'b0 || cmp_cnt !== 16'd0) $display("FAIL rstl_idle got %b/%0d exp 0/0", relatch, cmp_cnt); else passed++;
  endtask

  task automatic test_disable_mid_wait();
    do_reset();
    top_cnt = 16'd255; step = 16'd10; period_div = 16'd2; en = 1'b1;
    tick();
    pulse(); tick(); pulse(); tick();
    total++; if (cmp_cnt !== 16'd10) $display("FAIL dis_pre got %0d exp 10", cmp_cnt); else passed++;
    pulse();
    en = 1'b0;
    tick();
    pulse();
    total++; if (relatch !== 1'b0 || cmp_cnt !== 16'd10) $display("FAIL dis_idle got %b/%0d exp 0/10", relatch, cmp_cnt); else passed++;
    en = 1'b1;
    tick();
    pulse();
    total++; if (relatch !== 1'b0 || cmp_cnt !== 16'd10) $display("FAIL dis_divclr got %b/%0d exp 0/10", relatch, cmp_cnt); else passed++;
    tick();
    pulse();
    total++; if (relatch !== 1'b1 || cmp_cnt !== 16'd20) $display("FAIL dis_resume got %b/%0d exp 1/20", relatch, cmp_cnt); else passed++;
  endtask

  task automatic test_back_to_back();
    do_reset();
    top_cnt = 16'd255; step = 16'd7; period_div = 16'd2; en = 1'b1;
    tick();
    pulse(); tick();
    top_match = 1'b1;
    tick();
    total++; if (relatch !== 1'b1 || cmp_cnt !== 16'd7) $display("FAIL b2b_first got %b/%0d exp 1/7", relatch, cmp_cnt); else passed++;
    tick();
    top_match = 1'b0;
    total++; if (relatch !== 1'b0) $display("FAIL b2b_single got %b exp 0", relatch); else passed++;
    tick();
    pulse();
    total++; if (relatch !== 1'b1 || cmp_cnt !== 16'd14) $display("FAIL b2b_counted got %b/%0d exp 1/14", relatch, cmp_cnt); else passed++;
  endtask

  initial begin
    test_reset();
    test_unit_ramp();
    test_ramp_div2();
    test_div_zero();
    test_top_lowered();
    test_step_zero();
    test_top_zero();
    test_reset_in_latch();
    test_disable_mid_wait();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
